decode_stage: RTL and testbench

Registered RV32I decode pipeline stage that replaces the purely combinational decoder in the CPU front end. Accepts an instruction word and PC through a valid/ready handshake and decodes fields, op classes and a sign-extended immediate. Presents the result one cycle later through an output handshake with a skid buffer. Adds immediate generation, strict illegal-instruction detection, pipeline flush and a saturating illegal-instruction counter.

---
 rtl/decode_pkg.sv | 124 ++++++++++++
 rtl/rv_decode_comb.sv | 146 ++++++++++++++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
/*============================================================================
 * Module : decode_pkg
 * Desc   : RV32I decode constants, op encodings and the decoded-entry layout.
 * Rev    : 1.0 - initial release
 *==========================================================================*/
`default_nettype none

package decode_pkg;

  localparam logic [4:0] c_opc_load     = 5'b00000;
  localparam logic [4:0] c_opc_custom0  = 5'b00010;
  localparam logic [4:0] c_opc_misc_mem = 5'b00011;
  localparam logic [4:0] c_opc_op_imm   = 5'b00100;
  localparam logic [4:0] c_opc_auipc    = 5'b00101;
  localparam logic [4:0] c_opc_store    = 5'b01000;
  localparam logic [4:0] c_opc_custom1  = 5'b01010;
  localparam logic [4:0] c_opc_op       = 5'b01100;
  localparam logic [4:0] c_opc_lui      = 5'b01101;
  localparam logic [4:0] c_opc_branch   = 5'b11000;
  localparam logic [4:0] c_opc_jalr     = 5'b11001;
  localparam logic [4:0] c_opc_jal      = 5'b11011;
  localparam logic [4:0] c_opc_system   = 5'b11100;

  localparam logic [3:0] c_cls_nop    = 4'd0;
  localparam logic [3:0] c_cls_alu    = 4'd1;
  localparam logic [3:0] c_cls_alui   = 4'd2;
  localparam logic [3:0] c_cls_load   = 4'd3;
  localparam logic [3:0] c_cls_store  = 4'd4;
  localparam logic [3:0] c_cls_branch = 4'd5;
  localparam logic [3:0] c_cls_jal    = 4'd6;
  localparam logic [3:0] c_cls_jalr   = 4'd7;
  localparam logic [3:0] c_cls_lui    = 4'd8;
  localparam logic [3:0] c_cls_auipc  = 4'd9;
  localparam logic [3:0] c_cls_csr    = 4'd10;
  localparam logic [3:0] c_cls_sys    = 4'd11;
  localparam logic [3:0] c_cls_cust   = 4'd12;

  localparam logic [4:0] c_alu_add  = 5'd0;
  localparam logic [4:0] c_alu_sub  = 5'd1;
  localparam logic [4:0] c_alu_sll  = 5'd2;
  localparam logic [4:0] c_alu_slt  = 5'd3;
  localparam logic [4:0] c_alu_sltu = 5'd4;
  localparam logic [4:0] c_alu_xor  = 5'd5;
  localparam logic [4:0] c_alu_srl  = 5'd6;
  localparam logic [4:0] c_alu_sra  = 5'd7;
  localparam logic [4:0] c_alu_or   = 5'd8;
  localparam logic [4:0] c_alu_and  = 5'd9;
  // MUL..REMU occupy 16..23 as {2'b10, funct3}
  localparam logic [4:0] c_alu_mul  = 5'd16;

  // Branch conditions, memory ops and CSR ops reuse funct3 directly
  localparam logic [3:0] c_br_eq  = 4'd0;
  localparam logic [3:0] c_br_ne  = 4'd1;
  localparam logic [3:0] c_br_lt  = 4'd4;
  localparam logic [3:0] c_br_ge  = 4'd5;
  localparam logic [3:0] c_br_ltu = 4'd6;
  localparam logic [3:0] c_br_geu = 4'd7;
  localparam logic [3:0] c_mem_b  = 4'd0;
  localparam logic [3:0] c_mem_h  = 4'd1;
  localparam logic [3:0] c_mem_w  = 4'd2;
  localparam logic [3:0] c_mem_bu = 4'd4;
  localparam logic [3:0] c_mem_hu = 4'd5;
  localparam logic [3:0] c_csr_rw  = 4'd1;
  localparam logic [3:0] c_csr_rs  = 4'd2;
  localparam logic [3:0] c_csr_rc  = 4'd3;
  localparam logic [3:0] c_csr_rwi = 4'd5;
  localparam logic [3:0] c_csr_rsi = 4'd6;
  localparam logic [3:0] c_csr_rci = 4'd7;

  localparam logic [3:0] c_sys_ecall  = 4'd0;
  localparam logic [3:0] c_sys_ebreak = 4'd1;
  localparam logic [3:0] c_sys_mret   = 4'd2;
  localparam logic [3:0] c_sys_sret   = 4'd3;
  localparam logic [3:0] c_sys_wfi    = 4'd4;

  localparam logic [31:0] c_word_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_word_ebreak = 32'h0010_0073;
  localparam logic [31:0] c_word_mret   = 32'h3020_0073;
  localparam logic [31:0] c_word_sret   = 32'h1020_0073;
  localparam logic [31:0] c_word_wfi    = 32'h1050_0073;

  localparam logic [2:0] c_imm_none = 3'd0;
  localparam logic [2:0] c_imm_i    = 3'd1;
  localparam logic [2:0] c_imm_s    = 3'd2;
  localparam logic [2:0] c_imm_b    = 3'd3;
  localparam logic [2:0] c_imm_u    = 3'd4;
  localparam logic [2:0] c_imm_j    = 3'd5;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_we;
    logic [3:0] cls;
    logic [4:0] alu_op;
    logic [3:0] sub_op;
    logic       illegal;
  } dec_ctrl_t;

  localparam int DEC_CTRL_W = $bits(dec_ctrl_t);

  // Full entry is {pc, imm, ctrl}
  function automatic int entry_w(input int xlen, input int pc_w);
    return pc_w + xlen + DEC_CTRL_W;
  endfunction

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'd0:    op = alt ? c_alu_sub : c_alu_add;
      3'd1:    op = c_alu_sll;
      3'd2:    op = c_alu_slt;
      3'd3:    op = c_alu_sltu;
      3'd4:    op = c_alu_xor;
      3'd5:    op = alt ? c_alu_sra : c_alu_srl;
      3'd6:    op = c_alu_or;
      default: op = c_alu_and;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_decode_comb.sv
/*============================================================================
 * Module : rv_decode_comb
 * Desc   : Combinational RV32I instruction decoder with immediate generation.
 *          DECODE_RV32M_EN enables decoding of the M-extension ops.
 * Rev    : 1.0 - initial release
 *==========================================================================*/
`default_nettype none

module rv_decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_ctrl_t       ctrl,
  output logic [XLEN-1:0] imm
);

  logic [4:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [3:0]  w_cls;
  logic [4:0]  w_alu;
  logic [3:0]  w_sub;
  logic [2:0]  w_fmt;
  logic        w_illegal;
  logic        w_writes;
  logic [31:0] w_imm32;

  assign w_opc = instr[6:2];
  assign w_f3  = instr[14:12];
  assign w_f7  = instr[31:25];

  always_comb begin
    w_cls     = c_cls_nop;
    w_alu     = c_alu_add;
    w_sub     = 4'd0;
    w_fmt     = c_imm_none;
    w_illegal = (instr[1:0] != 2'b11);
    case (w_opc)
      c_opc_load: begin
        w_cls = c_cls_load;
        w_fmt = c_imm_i;
        w_sub = {1'b0, w_f3};
        if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_illegal = 1'b1;
      end
      c_opc_misc_mem: w_cls = c_cls_nop;
      c_opc_op_imm: begin
        w_cls = c_cls_alui;
        w_fmt = c_imm_i;
        w_alu = alu_from_f3(w_f3, (w_f3 == 3'd5) && w_f7[5]);
        if (w_f3 == 3'd1 && w_f7 != 7'h00) w_illegal = 1'b1;
        if (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20) w_illegal = 1'b1;
      end
      c_opc_auipc: begin
        w_cls = c_cls_auipc;
        w_fmt = c_imm_u;
      end
      c_opc_store: begin
        w_cls = c_cls_store;
        w_fmt = c_imm_s;
        w_sub = {1'b0, w_f3};
        if (w_f3 > 3'd2) w_illegal = 1'b1;
      end
      c_opc_op: begin
        w_cls = c_cls_alu;
        if (w_f7 == 7'h00) w_alu = alu_from_f3(w_f3, 1'b0);
        else if (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)) w_alu = alu_from_f3(w_f3, 1'b1);
`ifdef DECODE_RV32M_EN
        else if (w_f7 == 7'h01) w_alu = c_alu_mul | {2'b00, w_f3};
`endif
        else w_illegal = 1'b1;
      end
      c_opc_lui: begin
        w_cls = c_cls_lui;
        w_fmt = c_imm_u;
      end
      c_opc_branch: begin
        w_cls = c_cls_branch;
        w_fmt = c_imm_b;
        w_sub = {1'b0, w_f3};
        if (w_f3 == 3'd2 || w_f3 == 3'd3) w_illegal = 1'b1;
      end
      c_opc_jalr: begin
        w_cls = c_cls_jalr;
        w_fmt = c_imm_i;
        if (w_f3 != 3'd0) w_illegal = 1'b1;
      end
      c_opc_jal: begin
        w_cls = c_cls_jal;
        w_fmt = c_imm_j;
      end
      c_opc_system: begin
        w_fmt = c_imm_i;
        if (w_f3 == 3'd0) begin
          w_cls = c_cls_sys;
          case (instr)
            c_word_ecall:  w_sub = c_sys_ecall;
            c_word_ebreak: w_sub = c_sys_ebreak;
            c_word_mret:   w_sub = c_sys_mret;
            c_word_sret:   w_sub = c_sys_sret;
            c_word_wfi:    w_sub = c_sys_wfi;
            default:       w_illegal = 1'b1;
          endcase
        end else begin
          w_cls = c_cls_csr;
          w_sub = {1'b0, w_f3};
          if (w_f3 == 3'd4) w_illegal = 1'b1;
        end
      end
      c_opc_custom0, c_opc_custom1: w_cls = c_cls_cust;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (w_fmt)
      c_imm_i: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      c_imm_s: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      c_imm_b: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      c_imm_u: w_imm32 = {instr[31:12], 12'b0};
      c_imm_j: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
  end

  assign w_writes = w_cls inside {c_cls_alu, c_cls_alui, c_cls_load, c_cls_jal,
                                  c_cls_jalr, c_cls_lui, c_cls_auipc, c_cls_csr};

  // Illegal entries are scrubbed to a harmless NOP carrying only the raw register fields
  always_comb begin
    ctrl.rd      = instr[11:7];
    ctrl.rs1     = instr[19:15];
    ctrl.rs2     = instr[24:20];
    ctrl.illegal = w_illegal;
    ctrl.rd_we   = !w_illegal && w_writes && (instr[11:7] != 5'd0);
    ctrl.cls     = w_illegal ? c_cls_nop : w_cls;
    ctrl.alu_op  = w_illegal ? c_alu_add : w_alu;
    ctrl.sub_op  = w_illegal ? 4'd0 : w_sub;
  end

  assign imm = w_illegal ? '0 : XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
/*============================================================================
 * Module : decode_stage
 * Desc   : Registered RV32I decode stage with skid buffer, flush and illegal
 *          counter. DECODE_RV32M_EN (see rv_decode_comb) enables M-extension.
 * Rev    : 1.0 - initial release
 *==========================================================================*/
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_rd_we,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_class,
  output logic [4:0]       out_alu_op,
  output logic [3:0]       out_sub_op,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int ENTRY_W = entry_w(XLEN, PC_W);

  dec_ctrl_t          w_ctrl;
  dec_ctrl_t          w_out_ctrl;
  logic [XLEN-1:0]    w_imm;
  logic [ENTRY_W-1:0] w_new;
  logic [ENTRY_W-1:0] w_skid;
  logic [ENTRY_W-1:0] r_out;
  logic               w_skid_valid;
  logic               r_out_valid;
  logic               w_load_out;
  logic               w_acc;
  logic               w_out_fire;
  logic [CNT_W-1:0]   r_cnt;

  rv_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .ctrl  (w_ctrl),
    .imm   (w_imm)
  );

  assign w_new      = {in_pc, w_imm, w_ctrl};
  assign w_load_out = !r_out_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  generate
    if (BUF_DEPTH >= 2) begin : g_skid
      logic               r_skid_valid;
      logic [ENTRY_W-1:0] r_skid;

      // Skid fills only while the output is stalled; it drains first when the output frees up
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid_valid <= 1'b0;
          r_skid       <= '0;
        end else if (flush || w_load_out) begin
          r_skid_valid <= 1'b0;
        end else if (w_acc) begin
          r_skid_valid <= 1'b1;
          r_skid       <= w_new;
        end
      end

      assign w_skid_valid = r_skid_valid;
      assign w_skid       = r_skid;
      assign in_ready     = !r_skid_valid;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid       = '0;
      assign in_ready     = w_load_out;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      if (w_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out       <= w_skid;
      end else if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out       <= w_new;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign {out_pc, out_imm, w_out_ctrl} = r_out;

  // A handshake coinciding with flush still completes, so it still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_out_fire && w_out_ctrl.illegal && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rd      = w_out_ctrl.rd;
  assign out_rs1     = w_out_ctrl.rs1;
  assign out_rs2     = w_out_ctrl.rs2;
  assign out_rd_we   = w_out_ctrl.rd_we;
  assign out_class   = w_out_ctrl.cls;
  assign out_alu_op  = w_out_ctrl.alu_op;
  assign out_sub_op  = w_out_ctrl.sub_op;
  assign out_illegal = w_out_ctrl.illegal;
  assign illegal_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
/*============================================================================
 * Module : tb_decode_stage
 * Desc   : Scoreboard bench for decode_stage against a rule-level RV32I model.
 *          Honours DECODE_RV32M_EN for the expected M-extension decode.
 * Rev    : 1.0 - initial release
 *==========================================================================*/
`default_nettype none

module tb_decode_stage;
  import decode_pkg::*;

  localparam int XLEN      = 32;
  localparam int PC_W      = 32;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd, rs1, rs2;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [3:0]      cls;
    logic [4:0]      alu;
    logic [3:0]      sub;
    logic            ill;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic in_ready, out_valid, out_rd_we, out_illegal;
  logic [PC_W-1:0] out_pc;
  logic [4:0] out_rd, out_rs1, out_rs2, out_alu_op;
  logic [XLEN-1:0] out_imm;
  logic [3:0] out_class, out_sub_op;
  logic [CNT_W-1:0] illegal_cnt;

  int total = 0, bad = 0;
  exp_t q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  bit flush_prev = 1'b0;
  logic [PC_W-1:0] pc_ctr = 32'h1000;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd_we(out_rd_we), .out_imm(out_imm), .out_class(out_class),
    .out_alu_op(out_alu_op), .out_sub_op(out_sub_op), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic longint u(input logic [31:0] x);
    return longint'(x);
  endfunction

  // Reference decode straight from the ISA rules; immediates built arithmetically
  function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] pc);
    exp_t e;
    int f3, f7, alu, cls, sub, fmt;
    int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    bit ok;
    longint imm;
    f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    ok = (w[1:0] == 2'b11);
    cls = 0; alu = 0; sub = 0; fmt = 0;
    case (w[6:2])
      5'b00000: begin cls = 3; sub = f3; fmt = 1; if (!(f3 inside {0, 1, 2, 4, 5})) ok = 0; end
      5'b00011: cls = 0;
      5'b00100: begin
        cls = 2; fmt = 1;
        alu = (f3 == 5 && f7 == 32) ? 7 : base[f3];
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5 && f7 != 0 && f7 != 32) ok = 0;
      end
      5'b00101: begin cls = 9; fmt = 4; end
      5'b01000: begin cls = 4; sub = f3; fmt = 2; if (f3 > 2) ok = 0; end
      5'b01100: begin
        cls = 1;
        if (f7 == 0) alu = base[f3];
        else if (f7 == 32 && f3 == 0) alu = 1;
        else if (f7 == 32 && f3 == 5) alu = 7;
`ifdef DECODE_RV32M_EN
        else if (f7 == 1) alu = 16 + f3;
`endif
        else ok = 0;
      end
      5'b01101: begin cls = 8; fmt = 4; end
      5'b11000: begin cls = 5; sub = f3; fmt = 3; if (f3 == 2 || f3 == 3) ok = 0; end
      5'b11001: begin cls = 7; fmt = 1; if (f3 != 0) ok = 0; end
      5'b11011: begin cls = 6; fmt = 5; end
      5'b11100: begin
        fmt = 1;
        if (f3 == 0) begin
          cls = 11;
          if (w == 32'h00000073) sub = 0;
          else if (w == 32'h00100073) sub = 1;
          else if (w == 32'h30200073) sub = 2;
          else if (w == 32'h10200073) sub = 3;
          else if (w == 32'h10500073) sub = 4;
          else ok = 0;
        end else begin
          cls = 10; sub = f3;
          if (f3 == 4) ok = 0;
        end
      end
      5'b00010, 5'b01010: cls = 12;
      default: ok = 0;
    endcase
    case (fmt)
      1: imm = u(w[31:20]) - u(w[31]) * 4096;
      2: imm = u(w[31:25]) * 32 + u(w[11:7]) - u(w[31]) * 4096;
      3: imm = u(w[30:25]) * 32 + u(w[11:8]) * 2 + u(w[7]) * 2048 - u(w[31]) * 4096;
      4: imm = u(w[31:12]) * 4096 - u(w[31]) * (longint'(1) << 32);
      5: imm = u(w[30:21]) * 2 + u(w[20]) * 2048 + u(w[19:12]) * 4096 - u(w[31]) * (1 << 20);
      default: imm = 0;
    endcase
    e = '0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.ill = !ok;
    if (ok) begin
      e.cls = 4'(cls); e.alu = 5'(alu); e.sub = 4'(sub); e.imm = imm[XLEN-1:0];
      e.rd_we = (cls inside {1, 2, 3, 6, 7, 8, 9, 10}) && (w[11:7] != 0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0] ops[15] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24,
                            5'd25, 5'd27, 5'd28, 5'd2, 5'd10, 5'd1, 5'd14};
    logic [31:0] sw[5] = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h10200073, 32'h10500073};
    int k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if (k == 0) return w;
    if (k == 1) return sw[$urandom_range(0, 4)];
    w[6:2] = ops[$urandom_range(0, 14)];
    w[1:0] = ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b11;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // One cycle of stimulus; held-entry count in the scoreboard predicts in_ready/out_valid
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, output bit acc);
    @(posedge clk); #1;
    if (flush_prev) q.delete();
    in_valid = v; in_instr = ins; in_pc = pc_ctr; out_ready = ordy; flush = fl;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, (BUF_DEPTH >= 2) ? (q.size() < 2) : (q.size() == 0 || ordy));
    @(negedge clk);
    acc = v && in_ready && !fl;
    if (acc) begin
      q.push_back(model(ins, pc_ctr));
      pc_ctr += 4;
    end
    flush_prev = fl;
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_payload", {out_pc, out_imm, out_class, out_illegal}, 0);
    q.delete(); exp_cnt = '0; flush_prev = 1'b0; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every completed output handshake
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("illegal_cnt", illegal_cnt, exp_cnt);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: got pc %h want no entry", out_pc);
          end else begin
            e = q.pop_front();
            a = '{out_pc, out_rd, out_rs1, out_rs2, out_rd_we, out_imm,
                  out_class, out_alu_op, out_sub_op, out_illegal};
            chk($sformatf("entry pc=%h", e.pc), a, e);
            if (e.ill && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] dir[6] = '{32'hFFF00093, 32'h402081B3, 32'hFE208EE3,
                            32'h00000000, 32'h00000073, 32'h022081B3};
    logic [31:0] str[4] = '{32'h00100093, 32'h00208133, 32'h0000A183, 32'h00312223};
    logic [31:0] cur;
    bit acc;
    int k;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_outs", {out_valid, out_pc, out_rd, out_rs1, out_rs2, out_rd_we, out_imm,
                       out_class, out_alu_op, out_sub_op, out_illegal, illegal_cnt}, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    foreach (dir[i]) step(1'b1, dir[i], 1'b1, 1'b0, acc);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    k = 0;
    for (int c = 0; c < 12; c++) begin
      cur = str[(k < 4) ? k : 0];
      step(k < 4, cur, c >= 3, 1'b0, acc);
      if (acc) k++;
    end

    step(1'b1, str[0], 1'b0, 1'b0, acc);
    step(1'b1, str[1], 1'b0, 1'b0, acc);
    step(1'b1, str[2], 1'b0, 1'b1, acc);
    step(1'b1, str[3], 1'b0, 1'b0, acc);
    step(1'b1, 32'h00500293, 1'b0, 1'b1, acc);
    step(1'b1, 32'h00000000, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    cur = rand_instr();
    for (int c = 0; c < 1500; c++) begin
      bit v;
      if (c == 700) mid_reset();
      v = $urandom_range(0, 9) < 7;
      step(v, cur, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, acc);
      if (acc || !v) cur = rand_instr();
    end

    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
